// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a NUM_DIGITS-digit 7-segment display
// that shares one segment bus. Digit values are held in a shadow register so
// that a multi-digit value is only ever swapped at a frame boundary and the
// display never shows a torn value. Each digit slot starts with an anode-off
// guard interval to prevent ghosting. Leading zeros can optionally be hidden.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   digits_in    BCD digits, [3:0] = digit 0 (least significant)
//   dp_in        decimal point per digit, 1 = lit, used live (not shadowed)
//   blank_lz     1 = suppress leading zeros, used live
//   upd_req      level request to load digits_in into the shadow register
//   upd_ack      one-cycle pulse: shadow has been loaded
//   frame_start  one-cycle pulse on the first cycle of each frame
//   seg_n        segments a..g on bits 0..6, active low
//   dp_n         decimal point, active low
//   an_n         anode enables, active low, bit i = digit i
//
// Update handshake: the requester raises upd_req and holds it, together with
// a stable digits_in, until it sees upd_ack. The block samples upd_req only
// on the last cycle of a frame; when high, digits_in is copied into the
// shadow and upd_ack pulses on the next cycle, which is also the frame_start
// cycle of the frame that first shows the new value. A request still high at
// the following frame end is loaded and acknowledged again, so at most one
// load happens per frame. Activity on upd_req between frame ends is ignored.
//
// All outputs are registered: the value seen after an edge reflects the scan
// position held by the counters just before that edge.
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    upd_req,
    output logic                    upd_ack,
    output logic                    frame_start,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF   = 7'h7F;

    // Scan position: cycle within the slot and the slot (digit) index.
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    ack_pend;

    logic                    last_cnt;
    logic                    last_idx;
    logic                    frame_end;
    logic                    in_blank;
    logic                    load_now;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_above;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_sup;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_OFF;  // non-BCD codes show nothing
        endcase
        return s;
    endfunction

    assign last_cnt  = (cnt == CNT_LAST);
    assign last_idx  = (idx == IDX_LAST);
    assign frame_end = last_cnt && last_idx;
    assign in_blank  = (cnt < CNT_BLANK);
    assign load_now  = frame_end && upd_req;

    // Leading-zero mask: digit i is hidden when it and every digit above it
    // are zero. Digit 0 is never hidden, so the loop stops at 1.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow[4*i +: 4] == 4'd0);
            lz_mask[i] = blank_lz && zero_above;
        end
    end

    // Select the data for the digit currently being scanned.
    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_sup   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = shadow[4*i +: 4];
                cur_dp    = dp_in[i];
                cur_sup   = lz_mask[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            shadow      <= '0;
            ack_pend    <= 1'b0;
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
            seg_n       <= SEG_OFF;
            dp_n        <= 1'b1;
            an_n        <= '1;
        end else begin
            // Explicit wrap keeps non-power-of-two digit counts correct.
            if (last_cnt) begin
                cnt <= '0;
                idx <= last_idx ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            frame_start <= (idx == '0) && (cnt == '0);

            // The load happens on the frame's last cycle; the ack is delayed
            // one cycle so it lines up with the next frame_start.
            ack_pend <= load_now;
            upd_ack  <= ack_pend;
            if (load_now) begin
                shadow <= digits_in;
            end

            if (in_blank) begin
                an_n  <= '1;
                seg_n <= SEG_OFF;
                dp_n  <= 1'b1;
            end else begin
                an_n  <= ~(NUM_DIGITS'(1) << idx);
                seg_n <= cur_sup ? SEG_OFF : decode(cur_digit);
                dp_n  <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2 (32-cycle frame). A reference model works from the absolute
// cycle number since reset (frame position, slot, offset by division) and a
// plain array of digit values; it pushes the expected output word for every
// edge into exp_q, and each edge's DUT outputs are compared against it.
// Directed scenarios add spot checks with fixed values, then a randomized
// run exercises digits, dp, blank_lz, requests and occasional resets.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * SD;
    localparam int EW    = N + 7 + 1 + 1 + 1;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   dp_in = '0;
    logic           blank_lz = 1'b0;
    logic           upd_req = 1'b0;
    logic           upd_ack;
    logic           frame_start;
    logic [6:0]     seg_n;
    logic           dp_n;
    logic [N-1:0]   an_n;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .frame_start (frame_start),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [EW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [3:0] m_shadow [N];
    int         m_cyc     = 0;   // cycle number the next non-reset edge produces
    bit         m_ack_due = 1'b0;
    int         cur_cyc   = -1;  // cycle number of the outputs currently visible

    // Predicts the outputs of the coming edge from the inputs now applied.
    task automatic model_edge();
        logic [N-1:0] e_an;
        logic [6:0]   e_seg;
        logic         e_dp, e_fs, e_ack;
        int           p, slot, rel, msd;
        e_an  = '1;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fs  = 1'b0;
        e_ack = 1'b0;
        if (rst) begin
            m_cyc     = 0;
            m_ack_due = 1'b0;
            for (int j = 0; j < N; j++) m_shadow[j] = 4'd0;
            cur_cyc   = -1;
        end else begin
            p     = m_cyc % FRAME;
            slot  = p / SD;
            rel   = p % SD;
            e_fs  = (p == 0);
            e_ack = m_ack_due;
            m_ack_due = 1'b0;
            if (rel >= BC) begin
                msd = -1;
                for (int j = 0; j < N; j++) if (m_shadow[j] != 4'd0) msd = j;
                e_an[slot] = 1'b0;
                if (blank_lz && slot != 0 && slot > msd) e_seg = 7'h7F;
                else e_seg = seg_tab[m_shadow[slot]];
                e_dp = ~dp_in[slot];
            end
            if (p == FRAME - 1 && upd_req) begin
                for (int j = 0; j < N; j++) m_shadow[j] = digits_in[4*j +: 4];
                m_ack_due = 1'b1;
            end
            cur_cyc = m_cyc;
            m_cyc++;
        end
        exp_q.push_back({e_ack, e_fs, e_dp, e_seg, e_an});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [EW-1:0] e;
        model_edge();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("an_n",        32'(an_n),        32'(e[N-1:0]));
        check_eq("seg_n",       32'(seg_n),       32'(e[N+6:N]));
        check_eq("dp_n",        32'(dp_n),        32'(e[N+7]));
        check_eq("frame_start", 32'(frame_start), 32'(e[N+8]));
        check_eq("upd_ack",     32'(upd_ack),     32'(e[N+9]));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (cur_cyc < target) tick();
    endtask

    int acks;

    // ---------------- stimulus ----------------
    initial begin
        // 1: reset and the empty scan sequence
        do_reset(3);
        check_eq("s1_rst_an", 32'(an_n), 32'hF);
        check_eq("s1_rst_seg", 32'(seg_n), 32'h7F);
        check_eq("s1_rst_ack", 32'(upd_ack), 32'h0);
        run_to(0);
        check_eq("s1_fs_c0", 32'(frame_start), 32'h1);
        run_to(2);
        check_eq("s1_an_c2", 32'(an_n), 32'b1110);
        check_eq("s1_seg_c2", 32'(seg_n), 32'h40);
        run_to(7);
        check_eq("s1_an_c7", 32'(an_n), 32'b1110);
        run_to(8);
        check_eq("s1_an_c8", 32'(an_n), 32'b1111);
        run_to(10);
        check_eq("s1_an_c10", 32'(an_n), 32'b1101);
        run_to(31);
        check_eq("s1_fs_c31", 32'(frame_start), 32'h0);
        run_to(32);
        check_eq("s1_fs_c32", 32'(frame_start), 32'h1);

        // 2: load 1234
        do_reset(2);
        digits_in = 16'h1234;
        run_to(5);
        upd_req = 1'b1;
        run_to(31);
        check_eq("s2_ack_c31", 32'(upd_ack), 32'h0);
        run_to(32);
        check_eq("s2_ack_c32", 32'(upd_ack), 32'h1);
        upd_req = 1'b0;
        run_to(33);
        check_eq("s2_ack_c33", 32'(upd_ack), 32'h0);
        run_to(36);
        check_eq("s2_seg_c36", 32'(seg_n), 32'h19);
        run_to(60);
        check_eq("s2_an_c60", 32'(an_n), 32'b0111);
        check_eq("s2_seg_c60", 32'(seg_n), 32'h79);

        // 3: leading zeros
        do_reset(2);
        digits_in = 16'h0050;
        blank_lz  = 1'b1;
        upd_req   = 1'b1;
        run_to(32);
        upd_req = 1'b0;
        run_to(36);
        check_eq("s3_seg_slot0", 32'(seg_n), 32'h40);
        run_to(44);
        check_eq("s3_seg_slot1", 32'(seg_n), 32'h12);
        run_to(52);
        check_eq("s3_an_slot2", 32'(an_n), 32'b1011);
        check_eq("s3_seg_slot2", 32'(seg_n), 32'h7F);
        run_to(60);
        check_eq("s3_an_slot3", 32'(an_n), 32'b0111);
        check_eq("s3_seg_slot3", 32'(seg_n), 32'h7F);
        blank_lz = 1'b0;
        run_to(92);
        check_eq("s3_seg_nolz", 32'(seg_n), 32'h40);

        // 4: invalid code and decimal point
        do_reset(2);
        digits_in = 16'h00A0;
        dp_in     = 4'b0010;
        upd_req   = 1'b1;
        run_to(32);
        upd_req = 1'b0;
        run_to(36);
        check_eq("s4_dp_slot0", 32'(dp_n), 32'h1);
        run_to(44);
        check_eq("s4_seg_slot1", 32'(seg_n), 32'h7F);
        check_eq("s4_dp_slot1", 32'(dp_n), 32'h0);
        run_to(52);
        check_eq("s4_dp_slot2", 32'(dp_n), 32'h1);
        dp_in = '0;

        // 5: reset mid-frame discards a pending request and clears the shadow
        do_reset(2);
        digits_in = 16'h8888;
        upd_req   = 1'b1;
        run_to(32);
        upd_req = 1'b0;
        run_to(51);
        digits_in = 16'h5555;
        upd_req   = 1'b1;
        run_to(56);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        upd_req = 1'b0;
        run_to(2);
        check_eq("s5_an_c2", 32'(an_n), 32'b1110);
        check_eq("s5_seg_c2", 32'(seg_n), 32'h40);
        run_to(32);
        check_eq("s5_ack_c32", 32'(upd_ack), 32'h0);

        // 6: sustained request, one load per frame
        do_reset(2);
        digits_in = 16'h0987;
        upd_req   = 1'b1;
        acks      = 0;
        repeat (70) begin
            tick();
            if (upd_ack === 1'b1) begin
                acks++;
                check_eq("s6_ack_cyc", 32'(cur_cyc), (acks == 1) ? 32'd32 : 32'd64);
                check_eq("s6_ack_fs", 32'(frame_start), 32'h1);
            end
        end
        upd_req = 1'b0;
        repeat (40) begin
            tick();
            if (upd_ack === 1'b1) acks++;
        end
        check_eq("s6_ack_count", 32'(acks), 32'd2);

        // 7: randomized traffic against the model
        do_reset(2);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                upd_req = 1'b0;
            end else begin
                rst = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) dp_in = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            if (!upd_req && $urandom_range(0, 7) == 0) begin
                for (int j = 0; j < N; j++)
                    digits_in[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                upd_req = 1'b1;
            end else if (upd_req && $urandom_range(0, 63) == 0) begin
                upd_req = 1'b0;  // abandoned request between frame ends
            end
            tick();
            if (upd_ack === 1'b1) upd_req = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
